// File: rtl/seg7_scroll_monitor.sv
// seg7_scroll_monitor: decodes sampled 7-segment digits and checks the scrolling message sequence
module seg7_scroll_monitor #(
  parameter logic [11:0] MESSAGE    = 12'h1BF,
  parameter int          PHASES     = 6,
  parameter int          LOCK_STEPS = 3
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        sample_en_i,
  input  logic [0:6]  hex0_i,
  input  logic [0:6]  hex1_i,
  input  logic [0:6]  hex2_i,
  input  logic [0:6]  hex3_i,
  input  logic [0:6]  hex4_i,
  input  logic [0:6]  hex5_i,
  output logic [11:0] frame_o,
  output logic        valid_o,
  output logic [2:0]  phase_o,
  output logic        locked_o,
  output logic        step_o,
  output logic        err_o,
  output logic [7:0]  err_count_o
);
  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;
  state_t      state_q, state_d;
  logic [11:0] frame_q, frame_d;
  logic [2:0]  phase_q, phase_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        valid_q, step_q, step_d, err_q, err_d, locked_q;
  logic [2:0]  d0, d1, d2, d3, d4, d5;
  logic [11:0] samp;
  logic        bad, hit;
  logic [2:0]  hit_k, nxt;
  // {illegal, code}
  function automatic logic [2:0] dec(input logic [0:6] s);
    return s == 7'b1000010 ? 3'b000 :
           s == 7'b0110000 ? 3'b001 :
           s == 7'b1001111 ? 3'b010 :
           s == 7'b1111111 ? 3'b011 : 3'b100;
  endfunction
  function automatic logic [11:0] rot(input logic [2:0] k);
    logic [23:0] mm;
    mm = {MESSAGE, MESSAGE} << (2 * k);
    return mm[23:12];
  endfunction
  assign d0   = dec(hex0_i);
  assign d1   = dec(hex1_i);
  assign d2   = dec(hex2_i);
  assign d3   = dec(hex3_i);
  assign d4   = dec(hex4_i);
  assign d5   = dec(hex5_i);
  assign samp = {d5[1:0], d4[1:0], d3[1:0], d2[1:0], d1[1:0], d0[1:0]};
  assign bad  = d0[2] | d1[2] | d2[2] | d3[2] | d4[2] | d5[2];
  assign nxt  = (phase_q == 3'(PHASES - 1)) ? 3'd0 : phase_q + 3'd1;
  // descending scan so the lowest matching phase is the one kept
  always_comb begin
    hit   = 1'b0;
    hit_k = 3'd0;
    for (int k = PHASES - 1; k >= 0; k--) begin
      if (samp == rot(3'(k))) begin
        hit   = 1'b1;
        hit_k = 3'(k);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    if (sample_en_i) begin
      frame_d = bad ? frame_q : samp;
      if (state_q == HUNT) begin
        if (!bad && hit) begin
          state_d = TRACK;
          phase_d = hit_k;
          cnt_d   = 4'd0;
        end else begin
          err_d = 1'b1;
        end
      end else if (!bad && samp == rot(phase_q)) begin
        state_d = state_q;
      end else if (!bad && samp == rot(nxt)) begin
        phase_d = nxt;
        step_d  = 1'b1;
        if (state_q == TRACK) begin
          cnt_d   = cnt_q + 4'd1;
          state_d = (cnt_q + 4'd1 == 4'(LOCK_STEPS)) ? LOCKED : TRACK;
        end
      end else begin
        err_d   = 1'b1;
        state_d = HUNT;
        cnt_d   = 4'd0;
      end
    end
  end
  assign err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q   <= HUNT;
      frame_q   <= 12'h000;
      phase_q   <= 3'd0;
      cnt_q     <= 4'd0;
      err_cnt_q <= 8'd0;
      valid_q   <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      valid_q   <= sample_en_i;
      step_q    <= step_d;
      err_q     <= err_d;
      locked_q  <= state_d == LOCKED;
    end
  end
  assign frame_o     = frame_q;
  assign valid_o     = valid_q;
  assign phase_o     = phase_q;
  assign locked_o    = locked_q;
  assign step_o      = step_q;
  assign err_o       = err_q;
  assign err_count_o = err_cnt_q;
endmodule

// File: tb/tb_seg7_scroll_monitor.sv
// tb_seg7_scroll_monitor: directed scroll sequences checked against a queued behavioural model
module tb_seg7_scroll_monitor;
  localparam logic [11:0] MSG = 12'h1BF;
  localparam int PH = 6;
  localparam int LS = 3;
  typedef struct packed {
    logic [11:0] frame;
    logic [2:0]  phase;
    logic        locked;
    logic        step;
    logic        err;
    logic [7:0]  errc;
  } exp_t;
  logic        clk = 1'b0;
  logic        aclr = 1'b0;
  logic        sample_en = 1'b0;
  logic [0:6]  hex [6];
  logic [11:0] frame;
  logic        valid, locked, step, err;
  logic [2:0]  phase;
  logic [7:0]  err_count;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        sb [$];
  int          m_state = 0;
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [11:0] m_frame = 12'h000;
  logic [7:0]  m_errc = 8'd0;
  always #5 clk = ~clk;
  seg7_scroll_monitor #(.MESSAGE(MSG), .PHASES(PH), .LOCK_STEPS(LS)) dut (
    .clk(clk), .aclr(aclr), .sample_en_i(sample_en),
    .hex0_i(hex[0]), .hex1_i(hex[1]), .hex2_i(hex[2]),
    .hex3_i(hex[3]), .hex4_i(hex[4]), .hex5_i(hex[5]),
    .frame_o(frame), .valid_o(valid), .phase_o(phase), .locked_o(locked),
    .step_o(step), .err_o(err), .err_count_o(err_count)
  );
  function automatic logic [0:6] seg(input logic [1:0] c);
    logic [0:6] s;
    case (c)
      2'b00:   s = 7'b1000010;
      2'b01:   s = 7'b0110000;
      2'b10:   s = 7'b1001111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction
  function automatic logic [11:0] fr(input int k);
    logic [11:0] m, r;
    m = MSG;
    for (int i = 0; i < 6; i++) r[2*i +: 2] = m[2*((i - k + 6) % 6) +: 2];
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic strobe(input logic [11:0] f, input bit bad3);
    exp_t e;
    int   hk;
    int   nx;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) hex[i] = seg(f[2*i +: 2]);
    if (bad3) hex[3] = 7'b0000000;
    sample_en = 1'b1;
    e.step = 1'b0;
    e.err  = 1'b0;
    if (!bad3) m_frame = f;
    nx = (m_phase + 1) % PH;
    if (m_state == 0) begin
      hk = -1;
      for (int k = PH - 1; k >= 0; k--) if (!bad3 && f == fr(k)) hk = k;
      if (hk >= 0) begin
        m_state = 1;
        m_phase = hk;
        m_cnt   = 0;
      end else e.err = 1'b1;
    end else if (!bad3 && f == fr(m_phase)) begin
      m_cnt = m_cnt;
    end else if (!bad3 && f == fr(nx)) begin
      m_phase = nx;
      e.step  = 1'b1;
      if (m_state == 1) begin
        m_cnt++;
        if (m_cnt == LS) m_state = 2;
      end
    end else begin
      e.err   = 1'b1;
      m_state = 0;
      m_cnt   = 0;
    end
    if (e.err && m_errc != 8'hFF) m_errc++;
    e.frame  = m_frame;
    e.phase  = 3'(m_phase);
    e.locked = m_state == 2;
    e.errc   = m_errc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    chk("valid", 32'(valid), 32'd1);
    if (valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("frame", 32'(frame), 32'(e.frame));
      chk("phase", 32'(phase), 32'(e.phase));
      chk("locked", 32'(locked), 32'(e.locked));
      chk("step", 32'(step), 32'(e.step));
      chk("err", 32'(err), 32'(e.err));
      chk("err_count", 32'(err_count), 32'(e.errc));
      chk("step_err_excl", 32'(step & err), 32'd0);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_frame"}, 32'(frame), 32'd0);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_step"}, 32'(step), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_errc"}, 32'(err_count), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 6; i++) hex[i] = 7'b1111111;
    #12;
    check_zero("reset");
    aclr = 1'b1;
    chk("frame0_const", 32'(fr(0)), 32'h1BF);
    // scenario 1: acquire at phase 0, lock after three steps
    strobe(fr(0), 1'b0);
    chk("hunt_phase", 32'(phase), 32'd0);
    strobe(fr(1), 1'b0);
    strobe(fr(2), 1'b0);
    chk("not_yet_locked", 32'(locked), 32'd0);
    strobe(fr(3), 1'b0);
    chk("locked_after3", 32'(locked), 32'd1);
    @(posedge clk);
    #1;
    chk("valid_idle", 32'(valid), 32'd0);
    chk("step_idle", 32'(step), 32'd0);
    // scenario 2: wrap 5 -> 0 while locked
    strobe(fr(4), 1'b0);
    strobe(fr(5), 1'b0);
    strobe(fr(0), 1'b0);
    chk("wrap_phase", 32'(phase), 32'd0);
    chk("wrap_step", 32'(step), 32'd1);
    chk("wrap_locked", 32'(locked), 32'd1);
    strobe(fr(1), 1'b0);
    strobe(fr(2), 1'b0);
    // scenario 3: repeated frame holds
    for (int i = 0; i < 3; i++) strobe(fr(2), 1'b0);
    chk("hold_phase", 32'(phase), 32'd2);
    // scenario 4: skip is an error
    strobe(fr(4), 1'b0);
    chk("skip_err", 32'(err), 32'd1);
    chk("skip_unlock", 32'(locked), 32'd0);
    chk("skip_errc", 32'(err_count), 32'd1);
    // scenario 5: illegal pattern keeps old frame
    strobe(fr(4), 1'b0);
    strobe(fr(5), 1'b1);
    chk("badpat_frame", 32'(frame), 32'(fr(4)));
    strobe(fr(5), 1'b1);
    strobe(12'hFFF, 1'b0);
    chk("nomatch_errc", 32'(err_count), 32'd4);
    // scenario 6: async reset mid-track
    strobe(fr(0), 1'b0);
    strobe(fr(1), 1'b0);
    #3;
    aclr = 1'b0;
    #1;
    check_zero("async");
    m_state = 0; m_phase = 0; m_cnt = 0; m_frame = 12'h000; m_errc = 8'd0;
    sb.delete();
    @(negedge clk);
    aclr = 1'b1;
    strobe(fr(3), 1'b0);
    chk("rehunt_phase", 32'(phase), 32'd3);
    strobe(fr(4), 1'b0);
    chk("queue_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
